// File: rtl/branch_predict_resolve_pkg.sv
// Shared encodings for branch prediction/resolution: EX branch/jump codes,
// PC redirect codes and the branch condition evaluator.
package branch_predict_resolve_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;
    localparam logic [1:0] J_RSVD = 2'b11;

    localparam logic [1:0] PCSRC_NONE   = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;
    localparam logic [1:0] PCSRC_SEQ    = 2'b11;

    // pos is signed a>b, so signed a<b is "neither greater nor equal".
    function automatic logic br_taken(input logic [2:0] br, input logic zero,
                                      input logic pos, input logic ltu);
        case (br)
            BR_BEQ:  return zero;
            BR_BNE:  return ~zero;
            BR_BLT:  return ~pos & ~zero;
            BR_BGE:  return pos | zero;
            BR_BLTU: return ltu;
            BR_BGEU: return ~ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_predict_resolve_btb.sv
// Direct-mapped BTB storage: fetch-side lookup, EX-side lookup for the counter
// update, and one synchronous write port (reads see pre-edge contents).
module branch_predict_resolve_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [CTR_W-1:0] rd_ctr,
    output logic [XLEN-1:0]  rd_target,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic [TAG_W-1:0] ex_tag,
    output logic             ex_hit,
    output logic [CTR_W-1:0] ex_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target,
    input  logic [CTR_W-1:0] wr_ctr
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];
    logic [CTR_W-1:0]   ctrs    [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= '0;
            end
        end else if (wr_en) begin
            valid[wr_idx]   <= wr_valid;
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
            ctrs[wr_idx]    <= wr_ctr;
        end
    end

    assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_ctr    = ctrs[rd_idx];
    assign rd_target = targets[rd_idx];
    assign ex_hit    = valid[ex_idx] && (tags[ex_idx] == ex_tag);
    assign ex_ctr    = ctrs[ex_idx];

endmodule

// File: rtl/branch_predict_resolve.sv
// BTB-based branch predictor (fetch) and branch resolver (execute) with
// misprediction redirect codes and saturating statistics.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   PCF,
    output logic              predTakenF,
    output logic [XLEN-1:0]   predTargetF,
    input  logic              validE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [2:0]        BranchE,
    input  logic [1:0]        JumpE,
    input  logic              zero,
    input  logic              pos,
    input  logic              ltu,
    input  logic              predTakenE,
    input  logic [XLEN-1:0]   predTargetE,
    input  logic [XLEN-1:0]   TargetE,
    output logic [1:0]        PCSrcE,
    output logic              mispredictE,
    output logic [STAT_W-1:0] statBranches,
    output logic [STAT_W-1:0] statMispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic             f_hit, e_hit;
    logic [CTR_W-1:0] f_ctr, e_ctr;
    logic [XLEN-1:0]  f_target;
    logic             is_cond, is_jal, is_jalr, taken, upd, alias_inv, wr_en;
    logic [CTR_W-1:0] wr_ctr;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    branch_predict_resolve_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (PCF[IDX_W+1:2]),
        .rd_tag    (PCF[XLEN-1:IDX_W+2]),
        .rd_hit    (f_hit),
        .rd_ctr    (f_ctr),
        .rd_target (f_target),
        .ex_idx    (PCE[IDX_W+1:2]),
        .ex_tag    (PCE[XLEN-1:IDX_W+2]),
        .ex_hit    (e_hit),
        .ex_ctr    (e_ctr),
        .wr_en     (wr_en),
        .wr_idx    (PCE[IDX_W+1:2]),
        .wr_valid  (upd),
        .wr_tag    (PCE[XLEN-1:IDX_W+2]),
        .wr_target (TargetE),
        .wr_ctr    (wr_ctr)
    );

    assign predTakenF  = f_hit & f_ctr[CTR_W-1];
    assign predTargetF = f_hit ? f_target : '0;

    assign is_cond = (BranchE != BR_NONE) && (BranchE != BR_RSVD);
    assign is_jal  = (JumpE == J_JAL);
    assign is_jalr = (JumpE == J_JALR);
    assign taken   = is_jal | (is_cond & br_taken(BranchE, zero, pos, ltu));

    always_comb begin
        PCSrcE = PCSRC_NONE;
        if (validE) begin
            if (is_jalr)
                PCSrcE = PCSRC_JALR;
            else if (taken && (!predTakenE || predTargetE != TargetE))
                PCSrcE = PCSRC_TARGET;
            else if (!taken && predTakenE)
                PCSrcE = PCSRC_SEQ;
        end
    end
    assign mispredictE = (PCSrcE != PCSRC_NONE);

    // A predicted-taken non-branch means the entry aliased onto it; drop it.
    assign upd       = validE & (is_cond | is_jal);
    assign alias_inv = validE & ~(is_cond | is_jal) & predTakenE;
    assign wr_en     = (upd & (e_hit | taken)) | alias_inv;

    always_comb begin
        wr_ctr = '0;
        if (is_jal)
            wr_ctr = CTR_MAX;
        else if (!e_hit)
            wr_ctr = CTR_WEAK;
        else if (taken)
            wr_ctr = (e_ctr == CTR_MAX) ? CTR_MAX : e_ctr + CTR_W'(1);
        else
            wr_ctr = (e_ctr == '0) ? '0 : e_ctr - CTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statBranches <= '0;
            statMispred  <= '0;
        end else if (upd) begin
            if (statBranches != STAT_MAX)
                statBranches <= statBranches + STAT_W'(1);
            if (mispredictE && statMispred != STAT_MAX)
                statMispred <= statMispred + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed scenarios plus randomized traffic against a behavioural BTB model.
module tb_branch_predict_resolve;

    localparam int XLEN = 32, ENTRIES = 4, CTR_W = 2, STAT_W = 4;
    localparam int CMAX = 3, SMAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [XLEN-1:0]   PCF, PCE, predTargetE, TargetE, predTargetF;
    logic [2:0]        BranchE;
    logic [1:0]        JumpE, PCSrcE;
    logic              validE, zero, pos, ltu, predTakenE, predTakenF, mispredictE;
    logic [STAT_W-1:0] statBranches, statMispred;

    branch_predict_resolve #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .predTakenF(predTakenF), .predTargetF(predTargetF),
        .validE(validE), .PCE(PCE), .BranchE(BranchE), .JumpE(JumpE),
        .zero(zero), .pos(pos), .ltu(ltu), .predTakenE(predTakenE),
        .predTargetE(predTargetE), .TargetE(TargetE), .PCSrcE(PCSrcE),
        .mispredictE(mispredictE), .statBranches(statBranches), .statMispred(statMispred)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: one record per BTB slot, plain integers for counters.
    bit          m_v   [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];
    int          m_nbr, m_nmis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && m_ctr[idx_of(pc)] >= (CMAX + 1) / 2;
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'h0;
    endfunction

    function automatic bit ref_taken(input logic [2:0] br, input logic [1:0] jmp,
                                     input logic [31:0] a, input logic [31:0] b);
        if (jmp == 2'd1) return 1'b1;
        case (br)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) <  $signed(b);
            3'd4: return $signed(a) >= $signed(b);
            3'd5: return a <  b;
            3'd6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_nbr = 0; m_nmis = 0;
    endtask

    // One EX resolution + one F lookup; called at posedge+1, returns at posedge+1.
    task automatic step(input logic [31:0] pcf, input logic [31:0] pce,
                        input logic [2:0] br, input logic [1:0] jmp,
                        input logic [31:0] a, input logic [31:0] b, input bit v,
                        input bit pt, input logic [31:0] ptg, input logic [31:0] tgt,
                        output logic [1:0] pcs_obs, output logic ptf_obs);
        bit cond, jal, tk;
        int ei, exp_pcs;
        bit exp_ptf;
        logic [31:0] exp_ptgf;
        PCF = pcf; PCE = pce; BranchE = br; JumpE = jmp; validE = v;
        zero = (a == b); pos = ($signed(a) > $signed(b)); ltu = (a < b);
        predTakenE = pt; predTargetE = ptg; TargetE = tgt;
        cond = (br >= 3'd1 && br <= 3'd6);
        jal  = (jmp == 2'd1);
        tk   = ref_taken(br, jmp, a, b);
        exp_ptf  = m_pred(pcf);
        exp_ptgf = m_ptgt(pcf);
        if (!v)                         exp_pcs = 0;
        else if (jmp == 2'd2)           exp_pcs = 2;
        else if (tk && (!pt || ptg != tgt)) exp_pcs = 1;
        else if (!tk && pt)             exp_pcs = 3;
        else                            exp_pcs = 0;
        @(negedge clk);
        chk("predTakenF", predTakenF, exp_ptf);
        chk("predTargetF", predTargetF, exp_ptgf);
        chk("PCSrcE", PCSrcE, exp_pcs);
        chk("mispredictE", mispredictE, exp_pcs != 0);
        pcs_obs = PCSrcE;
        ptf_obs = predTakenF;
        @(posedge clk);
        ei = idx_of(pce);
        if (v && (cond || jal)) begin
            if (m_hit(pce)) begin
                m_tgt[ei] = tgt;
                if (jal)     m_ctr[ei] = CMAX;
                else if (tk) m_ctr[ei] = (m_ctr[ei] < CMAX) ? m_ctr[ei] + 1 : CMAX;
                else         m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
            end else if (tk) begin
                m_v[ei] = 1; m_tag[ei] = tag_of(pce); m_tgt[ei] = tgt;
                m_ctr[ei] = jal ? CMAX : (CMAX + 1) / 2;
            end
            if (m_nbr < SMAX) m_nbr++;
            if (exp_pcs != 0 && m_nmis < SMAX) m_nmis++;
        end else if (v && pt) begin
            m_v[ei] = 0;
        end
        #1;
        chk("statBranches", statBranches, m_nbr);
        chk("statMispred", statMispred, m_nmis);
    endtask

    logic [1:0]  pcs;
    logic        ptf;
    logic [31:0] pc_r, pcf_r, a_r, b_r, ptg_r, tgt_r;
    logic [2:0]  br_r;
    logic [1:0]  jmp_r;
    bit          pt_r;

    initial begin
        rst = 1'b1; PCF = 0; PCE = 0; BranchE = 0; JumpE = 0; validE = 0;
        zero = 0; pos = 0; ltu = 0; predTakenE = 0; predTargetE = 0; TargetE = 0;
        model_reset();
        #12;
        chk("reset_predTakenF", predTakenF, 0);
        chk("reset_statBranches", statBranches, 0);
        chk("reset_statMispred", statMispred, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // BEQ taken three times: cold miss, then weak->strong taken
        step(32'h100, 32'h100, 3'd1, 2'd0, 5, 5, 1, 0, 0, 32'h180, pcs, ptf);
        chk("t2_first", pcs, 2'b01);
        step(32'h100, 32'h100, 3'd1, 2'd0, 5, 5, 1, 1, 32'h180, 32'h180, pcs, ptf);
        chk("t2_second", pcs, 2'b00);
        chk("t2_pred_on", ptf, 1);
        step(32'h100, 32'h100, 3'd1, 2'd0, 5, 5, 1, 1, 32'h180, 32'h180, pcs, ptf);
        chk("t2_third", pcs, 2'b00);

        // Not taken while predicted: two steps down to weak not-taken
        step(32'h100, 32'h100, 3'd1, 2'd0, 1, 2, 1, 1, 32'h180, 32'h180, pcs, ptf);
        chk("t3_nt1", pcs, 2'b11);
        step(32'h100, 32'h100, 3'd1, 2'd0, 1, 2, 1, 1, 32'h180, 32'h180, pcs, ptf);
        chk("t3_nt2", pcs, 2'b11);
        step(32'h100, 32'h100, 3'd1, 2'd0, 5, 5, 1, 0, 32'h180, 32'h180, pcs, ptf);
        chk("t3_taken_unpred", pcs, 2'b01);
        chk("t3_pred_off", ptf, 0);

        // Unsigned compares and reserved encoding
        step(32'h204, 32'h204, 3'd5, 2'd0, 1, 2, 1, 0, 0, 32'h280, pcs, ptf);
        chk("t4_bltu", pcs, 2'b01);
        step(32'h208, 32'h208, 3'd6, 2'd0, 32'hFFFF_FFFF, 2, 1, 0, 0, 32'h280, pcs, ptf);
        chk("t4_bgeu_t", pcs, 2'b01);
        step(32'h20c, 32'h20c, 3'd6, 2'd0, 1, 2, 1, 0, 0, 32'h280, pcs, ptf);
        chk("t4_bgeu_nt", pcs, 2'b00);
        step(32'h300, 32'h300, 3'd7, 2'd0, 5, 5, 1, 0, 0, 32'h380, pcs, ptf);
        chk("t4_rsvd", pcs, 2'b00);
        step(32'h300, 32'h0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, pcs, ptf);
        chk("t4_rsvd_noalloc", ptf, 0);

        // JALR never allocates; JAL target rewritten on hit
        step(32'h400, 32'h400, 3'd0, 2'd2, 0, 0, 1, 0, 0, 32'h480, pcs, ptf);
        chk("t5_jalr", pcs, 2'b10);
        step(32'h400, 32'h500, 3'd0, 2'd1, 0, 0, 1, 0, 0, 32'h600, pcs, ptf);
        chk("t5_jalr_noalloc", ptf, 0);
        chk("t5_jal_miss", pcs, 2'b01);
        step(32'h500, 32'h500, 3'd0, 2'd1, 0, 0, 1, 1, 32'h600, 32'h700, pcs, ptf);
        chk("t5_jal_newtgt", pcs, 2'b01);
        step(32'h500, 32'h0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, pcs, ptf);
        chk("t5_tgt_rewritten", predTargetF, 32'h700);

        // Bubble does nothing; aliasing PCs 0x0/0x10 share index 0
        step(32'h800, 32'h800, 3'd1, 2'd0, 5, 5, 0, 0, 0, 32'h880, pcs, ptf);
        chk("t6_bubble", pcs, 2'b00);
        step(32'h800, 32'h0, 3'd1, 2'd0, 5, 5, 1, 0, 0, 32'h40, pcs, ptf);
        chk("t6_bubble_noalloc", ptf, 0);
        step(32'h10, 32'h0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, pcs, ptf);
        chk("t6_alias_miss", ptf, 0);
        step(32'h0, 32'h0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, pcs, ptf);
        chk("t6_alias_home", ptf, 1);

        // Randomized traffic over a small PC pool to force aliasing
        for (int n = 0; n < 400; n++) begin
            pc_r  = 32'($urandom_range(0, 15)) << 2;
            pcf_r = 32'($urandom_range(0, 15)) << 2;
            br_r  = 3'($urandom_range(0, 7));
            jmp_r = (br_r == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            a_r   = 32'($urandom_range(0, 3)) - 32'd1;
            b_r   = 32'($urandom_range(0, 3)) - 32'd1;
            tgt_r = 32'($urandom_range(1, 3)) << 6;
            if ($urandom_range(0, 3) != 0) begin
                pt_r = m_pred(pc_r); ptg_r = m_ptgt(pc_r);
            end else begin
                pt_r = 1'($urandom_range(0, 1)); ptg_r = 32'($urandom_range(1, 3)) << 6;
            end
            step(pcf_r, pc_r, br_r, jmp_r, a_r, b_r, $urandom_range(0, 7) != 0,
                 pt_r, ptg_r, tgt_r, pcs, ptf);
        end

        // Mid-run reset with a known-valid entry
        step(32'h900, 32'h900, 3'd0, 2'd1, 0, 0, 1, 0, 0, 32'hA00, pcs, ptf);
        validE = 0; PCF = 32'h900;
        #2;
        chk("pre_rst_pred", predTakenF, 1);
        rst = 1'b1;
        #1;
        chk("rst_pred", predTakenF, 0);
        chk("rst_statBranches", statBranches, 0);
        chk("rst_statMispred", statMispred, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        step(32'h900, 32'h900, 3'd1, 2'd0, 5, 5, 1, 0, 0, 32'h980, pcs, ptf);
        chk("post_rst_first", pcs, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
